// File: rtl/rs232_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared rs232_send port.
// The arbiter uses the master modport; the byte sources and transmitter use the slave modport.
interface rs232_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;

  modport master (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant
  );

  modport slave (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant
  );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one rs232_send among N byte sources.
// Each grant can be prefixed with a channel-ID header byte.
module rs232_tx_arbiter #(
  parameter int         N           = 4,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BASE = 8'hF0,
  parameter int         MAX_BURST   = 0
) (
  input  logic               clock,
  input  logic               reset,
  rs232_tx_arbiter_if.master bus
);
  localparam int          IW        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NU        = N;
  localparam logic [15:0] BURST_LIM = 16'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] last_id_q, last_id_d;
  logic [15:0]   burst_cnt_q, burst_cnt_d;

  logic [IW-1:0] gid;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          found;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [N-1:0]  req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_id_q   <= IW'(N - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    gid = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (grant_q[i]) gid = IW'(i);
    end
  end

  // Scan wraps at N, not 2^IW, so non-power-of-two N never selects a missing id.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      idx = IW'((32'(last_id_q) + k) % NU);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    tx_data     = '0;
    tx_valid    = 1'b0;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          burst_cnt_d  = '0;
          state_d      = HEADER_EN ? HEADER : BODY;
        end
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BASE | 8'(gid);
        if (bus.tx_ready) state_d = BODY;
      end
      BODY: begin
        tx_data        = bus.req_data[{gid, 3'b000} +: 8];
        tx_valid       = bus.req_valid[gid];
        req_ready[gid] = bus.tx_ready;
        if (bus.req_valid[gid] && bus.tx_ready) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
          if (bus.req_last[gid] || (MAX_BURST != 0 && burst_cnt_q == BURST_LIM)) begin
            state_d   = IDLE;
            last_id_d = gid;
            grant_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;
  assign bus.req_ready = req_ready;
  assign bus.grant     = grant_q;
endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Shares one `rs232_send` transmitter among N byte-stream requesters. Arbitration is round-robin and packet-granular. An optional channel-ID header byte is inserted before each granted packet, so the host can demultiplex debug and telemetry streams arriving on a single serial line. The block sits between the on-chip byte sources and the transmitter's `data`/`valid`/`ready` port.

## Interface
- `N`, 4: number of requesters, 2..8.
- `HEADER_EN`, 1: when 1, emit one header byte per grant; when 0, no header.
- `HEADER_BASE`, 8'hF0: header byte is `HEADER_BASE | id`, where `id` is `$clog2(N)` bits zero-extended.
- `MAX_BURST`, 0: maximum body bytes per grant; 0 means unlimited (grant held until `last`).

- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_data`  in  N*8  requester i byte at bits [8i+7:8i].
- `req_valid`  in  N  requester i has a byte.
- `req_last`  in  N  requester i's current byte ends its packet.
- `req_ready`  out  N  requester i's byte is accepted this cycle.
- `tx_data`  out  8  byte to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  transmitter accepts the byte (the `ready` output of `rs232_send`).
- `grant`  out  N  one-hot current owner; all zeros when idle.

## Operation
- A transfer on either side happens in any cycle where valid && ready.
- Registered state:
  - `state`: IDLE, HEADER or BODY.
  - `grant`: one-hot owner.
  - `last_id`: index of the previous owner.
  - `burst_cnt`: 16-bit count of body bytes sent in this grant.
- Reset values:
  - `state` = IDLE.
  - `grant` = 0.
  - `last_id` = N-1, so requester 0 wins first.
  - `burst_cnt` = 0.
  - Hence `tx_valid` = 0 and `req_ready` = 0 out of reset.
- IDLE:
  - `tx_valid` = 0 and `req_ready` = 0.
  - If any `req_valid` is high, select the first set bit scanning `last_id+1, last_id+2, …` modulo N.
  - Load `grant` and clear `burst_cnt`.
  - Next state is HEADER if `HEADER_EN`, else BODY.
- HEADER:
  - `tx_valid` = 1 and `tx_data` = `HEADER_BASE | id(grant)`; `req_ready` = 0.
  - On `tx_ready`, go to BODY.
- BODY, with g = granted index:
  - `tx_data` = `req_data[g]` and `tx_valid` = `req_valid[g]`.
  - `req_ready[g]` = `tx_ready`; all other `req_ready` bits are 0.
  - This path is combinational from `tx_ready` to `req_ready` and from the requester inputs to `tx_data`/`tx_valid`.
- On a BODY transfer:
  - `burst_cnt` increments.
  - If `req_last[g]`, or if `MAX_BURST != 0` and `burst_cnt == MAX_BURST-1`: go to IDLE, set `last_id` <= g, clear `grant`.
- Bursts split by `MAX_BURST`:
  - The requester's remaining bytes compete again in a later arbitration.
  - They get a fresh header.
- While in BODY, a deasserted `req_valid[g]` keeps the grant: the arbiter waits with no timeout.
- `tx_data` is don't-care when `tx_valid` = 0.
- `req_data`/`req_last` of non-granted requesters are ignored.
- Requesters must hold valid, data and last stable until their transfer completes.

## Timing
- Arbitration latency: `req_valid` high in an IDLE cycle leads to `grant` and the HEADER (or BODY) state at the next edge, so the first `tx_valid` appears one cycle later.
- At least one IDLE cycle separates consecutive grants. A requester that wins again still pays the one-cycle arbitration and its header.
- Throughput is limited by the transmitter, about 10 bit-times per byte. The arbiter adds no extra wait beyond the IDLE/HEADER cycles.
- Requests arriving while a grant is active are held by their sources. They are considered only in the next IDLE cycle.
- `reset` asserted in any state:
  - At the next edge the block returns to IDLE with `grant` = 0 and `last_id` = N-1.
  - A byte already accepted by `rs232_send` still completes on the line.
  - Requesters must tolerate losing a partially sent packet.
- `N` not a power of two: ids range 0..N-1, and the round-robin scan wraps at N, not at 2^width.

## Test plan
- Single source, N=4, `HEADER_EN`=1: requester 2 sends 0x41, 0x42 (`last` on 0x42) → tx bytes 0xF2, 0x41, 0x42; `grant` = 4'b0100 during the packet, then 0.
- Contention: all four request 1-byte packets from reset → owner order 0, 1, 2, 3, then 0 again; headers 0xF0..0xF3, with one IDLE cycle between packets.
- Fairness: requester 1 requests continuously and requester 3 requests once → after 1's packet, 3 is granted before 1 is granted again.
- `MAX_BURST`=3, requester 0 sends a 5-byte packet alone → 0xF0 b0 b1 b2 0xF0 b3 b4; `burst_cnt` clears per grant.
- Backpressure and reset: hold `tx_ready` = 0 for 50 cycles in BODY → `req_ready` stays 0 and `tx_data` stays stable. Assert `reset` mid-packet → next cycle IDLE, `grant` = 0, `tx_valid` = 0, and requester 0 has priority afterwards.
